// File: rtl/pipe_pkg.sv
// Shared types for the pipeline sequencer: FSM encoding, register-number width
// and the per-stage enable/flush bundles used to build the output priority.
package pipe_pkg;

   localparam int REG_ADDR_W = 3;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      HALT     = 2'b10
   } state_t;

   typedef struct packed {
      logic pc;
      logic ifid;
      logic idex;
      logic exmem;
      logic memwb;
   } stage_en_t;

   typedef struct packed {
      logic ifid;
      logic idex;
      logic exmem;
      logic memwb;
   } stage_flush_t;

   localparam stage_en_t    EN_ALL   = '1;
   localparam stage_en_t    EN_NONE  = '0;
   localparam stage_flush_t FL_NONE  = '0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs from the datapath and stage-register controls back to it.
// master = datapath side, slave = the sequencer.
interface pipe_ctrl_if;
   import pipe_pkg::*;

   reg_addr_t id_rs;
   reg_addr_t id_rt;
   logic      id_rs_used;
   logic      id_rt_used;
   logic      ex_RegWrt;
   logic      mem_RegWrt;
   logic      wb_RegWrt;
   reg_addr_t ex_write_reg;
   reg_addr_t mem_write_reg;
   reg_addr_t wb_write_reg;
   logic      br_taken;
   logic      mem_req;
   logic      mem_done;
   logic      halt_in;

   logic      pc_en;
   logic      ifid_en;
   logic      idex_en;
   logic      exmem_en;
   logic      memwb_en;
   logic      ifid_flush;
   logic      idex_flush;
   logic      exmem_flush;
   logic      memwb_flush;

   modport master (
      output id_rs, id_rt, id_rs_used, id_rt_used,
             ex_RegWrt, mem_RegWrt, wb_RegWrt,
             ex_write_reg, mem_write_reg, wb_write_reg,
             br_taken, mem_req, mem_done, halt_in,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush
   );

   modport slave (
      input  id_rs, id_rt, id_rs_used, id_rt_used,
             ex_RegWrt, mem_RegWrt, wb_RegWrt,
             ex_write_reg, mem_write_reg, wb_write_reg,
             br_taken, mem_req, mem_done, halt_in,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush
   );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational RAW detector: does the instruction in ID read a register that an
// older in-flight instruction has not yet written back?
module hazard_detect
   import pipe_pkg::*;
#(
   parameter bit WB_BYPASS = 1'b1
) (
   input  reg_addr_t id_rs,
   input  reg_addr_t id_rt,
   input  logic      id_rs_used,
   input  logic      id_rt_used,
   input  logic      ex_RegWrt,
   input  logic      mem_RegWrt,
   input  logic      wb_RegWrt,
   input  reg_addr_t ex_write_reg,
   input  reg_addr_t mem_write_reg,
   input  reg_addr_t wb_write_reg,
   output logic      raw
);

   logic rs_hit;
   logic rt_hit;

   // r0 is an ordinary register here, so no zero-register exclusion.
   always_comb begin
      rs_hit = (ex_RegWrt  && (id_rs == ex_write_reg))
            || (mem_RegWrt && (id_rs == mem_write_reg))
            || ((WB_BYPASS == 1'b0) && wb_RegWrt && (id_rs == wb_write_reg));
      rt_hit = (ex_RegWrt  && (id_rt == ex_write_reg))
            || (mem_RegWrt && (id_rt == mem_write_reg))
            || ((WB_BYPASS == 1'b0) && wb_RegWrt && (id_rt == wb_write_reg));
      raw    = (id_rs_used && rs_hit) || (id_rt_used && rt_hit);
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-cycle advance/hold/bubble decisions for PC and the four
// stage registers, plus a data-memory timeout watchdog and stall-cycle counter.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter bit          WB_BYPASS   = 1'b1,
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   pipe_ctrl_if.slave       bus,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles
);

   if ((MEM_TIMEOUT < 2) || (MEM_TIMEOUT > 65535)) begin : g_bad_timeout
      $error("MEM_TIMEOUT must be in 2..65535");
   end

   localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [15:0]      wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] stall_q;
   logic             mem_err_q;
   logic             err_set;
   logic             raw;
   logic             mstall;
   logic             count_stall;
   stage_en_t        en;
   stage_flush_t     fl;

   hazard_detect #(
      .WB_BYPASS (WB_BYPASS)
   ) u_hazard (
      .id_rs         (bus.id_rs),
      .id_rt         (bus.id_rt),
      .id_rs_used    (bus.id_rs_used),
      .id_rt_used    (bus.id_rt_used),
      .ex_RegWrt     (bus.ex_RegWrt),
      .mem_RegWrt    (bus.mem_RegWrt),
      .wb_RegWrt     (bus.wb_RegWrt),
      .ex_write_reg  (bus.ex_write_reg),
      .mem_write_reg (bus.mem_write_reg),
      .wb_write_reg  (bus.wb_write_reg),
      .raw           (raw)
   );

   assign mstall = bus.mem_req && !bus.mem_done && (state_q != HALT);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d    = state_q;
      err_set    = 1'b0;
      en         = EN_ALL;
      fl         = FL_NONE;

      unique case (state_q)
         RUN: begin
            if (bus.halt_in)  state_d = HALT;
            else if (mstall)  state_d = MEM_WAIT;
         end
         MEM_WAIT: begin
            // A completion in the timeout cycle still counts as success.
            if (bus.mem_done) begin
               state_d = RUN;
            end else if (wait_cnt_q == TIMEOUT_LAST) begin
               state_d = HALT;
               err_set = 1'b1;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase

      if (state_q == HALT) begin
         en = EN_NONE;
      end else if ((state_q == RUN) && bus.halt_in) begin
         en = EN_NONE;
      end else if (mstall) begin
         // Freeze PC..EX/MEM; WB keeps draining and receives bubbles.
         en       = EN_NONE;
         en.memwb = 1'b1;
         fl.memwb = 1'b1;
      end else if (bus.br_taken) begin
         fl.ifid = 1'b1;
         fl.idex = 1'b1;
      end else if (raw) begin
         en.pc   = 1'b0;
         en.ifid = 1'b0;
         fl.idex = 1'b1;
      end

      wait_cnt_d = (state_q == MEM_WAIT) ? wait_cnt_q + 16'd1 : wait_cnt_q;
      if (state_d == RUN) wait_cnt_d = '0;
   end

   assign count_stall = (state_q != HALT) && !en.pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         stall_q    <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (err_set) mem_err_q <= 1'b1;
         if (count_stall && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      end
   end

   // Reset forces every stage to hold a bubble without needing a clock edge.
   assign bus.pc_en       = rst && en.pc;
   assign bus.ifid_en     = rst && en.ifid;
   assign bus.idex_en     = rst && en.idex;
   assign bus.exmem_en    = rst && en.exmem;
   assign bus.memwb_en    = rst && en.memwb;
   assign bus.ifid_flush  = !rst || fl.ifid;
   assign bus.idex_flush  = !rst || fl.idex;
   assign bus.exmem_flush = !rst || fl.exmem;
   assign bus.memwb_flush = !rst || fl.memwb;

   assign halted       = rst && (state_q == HALT);
   assign mem_err      = mem_err_q;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: two instances (WB bypass on, 16-bit counter;
// bypass off, 3-bit counter) share stimulus; a negedge monitor checks both.
module tb_pipe_ctrl;
   import pipe_pkg::*;

   localparam logic [4:0] E_ALL  = 5'b11111;
   localparam logic [4:0] E_RAW  = 5'b00111;
   localparam logic [4:0] E_MST  = 5'b00001;
   localparam logic [4:0] E_NONE = 5'b00000;
   localparam logic [3:0] F_NONE = 4'b0000;
   localparam logic [3:0] F_ALL  = 4'b1111;
   localparam logic [3:0] F_RAW  = 4'b0100;
   localparam logic [3:0] F_BR   = 4'b1100;
   localparam logic [3:0] F_MST  = 4'b0001;

   typedef struct packed {
      logic       rst;
      logic [2:0] rs;
      logic [2:0] rt;
      logic       rs_u;
      logic       rt_u;
      logic       ex_w;
      logic [2:0] ex_r;
      logic       mem_w;
      logic [2:0] mem_r;
      logic       wb_w;
      logic [2:0] wb_r;
      logic       br;
      logic       req;
      logic       done;
      logic       halt;
   } vec_t;

   typedef struct packed {
      logic [4:0]  en;
      logic [3:0]  fl;
      logic        halted;
      logic        err;
      logic [15:0] stall;
      logic [4:0]  en_nb;
      logic [3:0]  fl_nb;
      logic        halted_nb;
      logic        err_nb;
      logic [2:0]  stall_nb;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        halted0, err0, halted1, err1;
   logic [15:0] stall0;
   logic [2:0]  stall1;

   obs_t        exp_q[$];
   int          idx_q[$];
   int          checks = 0;
   int          errors = 0;
   int          vec_no = 0;
   logic [15:0] s0_m = '0;
   logic [2:0]  s1_m = '0;

   pipe_ctrl_if bus0 ();
   pipe_ctrl_if bus1 ();

   pipe_ctrl #(.WB_BYPASS(1'b1), .MEM_TIMEOUT(8), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0),
      .halted(halted0), .mem_err(err0), .stall_cycles(stall0)
   );

   pipe_ctrl #(.WB_BYPASS(1'b0), .MEM_TIMEOUT(8), .CNT_W(3)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .halted(halted1), .mem_err(err1), .stall_cycles(stall1)
   );

   always #5 clk = ~clk;

   function automatic vec_t idle();
      vec_t v;
      v     = '0;
      v.rst = 1'b1;
      return v;
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst                = v.rst;
      bus0.id_rs         = v.rs;    bus1.id_rs         = v.rs;
      bus0.id_rt         = v.rt;    bus1.id_rt         = v.rt;
      bus0.id_rs_used    = v.rs_u;  bus1.id_rs_used    = v.rs_u;
      bus0.id_rt_used    = v.rt_u;  bus1.id_rt_used    = v.rt_u;
      bus0.ex_RegWrt     = v.ex_w;  bus1.ex_RegWrt     = v.ex_w;
      bus0.ex_write_reg  = v.ex_r;  bus1.ex_write_reg  = v.ex_r;
      bus0.mem_RegWrt    = v.mem_w; bus1.mem_RegWrt    = v.mem_w;
      bus0.mem_write_reg = v.mem_r; bus1.mem_write_reg = v.mem_r;
      bus0.wb_RegWrt     = v.wb_w;  bus1.wb_RegWrt     = v.wb_w;
      bus0.wb_write_reg  = v.wb_r;  bus1.wb_write_reg  = v.wb_r;
      bus0.br_taken      = v.br;    bus1.br_taken      = v.br;
      bus0.mem_req       = v.req;   bus1.mem_req       = v.req;
      bus0.mem_done      = v.done;  bus1.mem_done      = v.done;
      bus0.halt_in       = v.halt;  bus1.halt_in       = v.halt;
   endtask

   // nb_raw: the no-bypass instance sees a RAW stall where the bypass one does not.
   task automatic step(input vec_t v, input logic [4:0] en, input logic [3:0] fl,
                       input logic hlt, input logic err, input logic nb_raw);
      obs_t e;
      @(posedge clk);
      #1;
      drive(v);
      if (!v.rst) begin
         s0_m = '0;
         s1_m = '0;
      end
      e.en        = en;
      e.fl        = fl;
      e.halted    = hlt;
      e.err       = err;
      e.stall     = s0_m;
      e.en_nb     = nb_raw ? E_RAW : en;
      e.fl_nb     = nb_raw ? F_RAW : fl;
      e.halted_nb = hlt;
      e.err_nb    = err;
      e.stall_nb  = s1_m;
      // Stall counters advance on the coming edge for non-HALT cycles with pc_en=0.
      if (v.rst && !hlt) begin
         if (!e.en[4] && (s0_m != 16'hFFFF)) s0_m = s0_m + 16'd1;
         if (!e.en_nb[4] && (s1_m != 3'h7))  s1_m = s1_m + 3'd1;
      end
      exp_q.push_back(e);
      idx_q.push_back(vec_no);
      vec_no++;
   endtask

   initial begin : monitor
      obs_t e, a;
      int   n;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = idx_q.pop_front();
            a.en        = {bus0.pc_en, bus0.ifid_en, bus0.idex_en, bus0.exmem_en, bus0.memwb_en};
            a.fl        = {bus0.ifid_flush, bus0.idex_flush, bus0.exmem_flush, bus0.memwb_flush};
            a.halted    = halted0;
            a.err       = err0;
            a.stall     = stall0;
            a.en_nb     = {bus1.pc_en, bus1.ifid_en, bus1.idex_en, bus1.exmem_en, bus1.memwb_en};
            a.fl_nb     = {bus1.ifid_flush, bus1.idex_flush, bus1.exmem_flush, bus1.memwb_flush};
            a.halted_nb = halted1;
            a.err_nb    = err1;
            a.stall_nb  = stall1;
            check($sformatf("vec%0d", n), a, e);
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin : stimulus
      vec_t v;
      v = idle(); v.rst = 1'b0;
      drive(v);

      // Reset, release, RAW hazards.
      step(v, E_NONE, F_ALL, 1'b0, 1'b0, 1'b0);
      v = idle();
      step(v, E_ALL, F_NONE, 1'b0, 1'b0, 1'b0);
      v = idle(); v.rs = 3'd3; v.rs_u = 1'b1; v.ex_w = 1'b1; v.ex_r = 3'd3;
      step(v, E_RAW, F_RAW, 1'b0, 1'b0, 1'b0);
      v = idle();
      step(v, E_ALL, F_NONE, 1'b0, 1'b0, 1'b0);
      v = idle(); v.rs = 3'd5; v.rs_u = 1'b1; v.wb_w = 1'b1; v.wb_r = 3'd5;
      step(v, E_ALL, F_NONE, 1'b0, 1'b0, 1'b1);
      v = idle(); v.rt = 3'd0; v.rt_u = 1'b1; v.mem_w = 1'b1; v.mem_r = 3'd0;
      step(v, E_RAW, F_RAW, 1'b0, 1'b0, 1'b0);
      v = idle(); v.rt = 3'd2; v.ex_w = 1'b1; v.ex_r = 3'd2;
      step(v, E_ALL, F_NONE, 1'b0, 1'b0, 1'b0);
      v = idle(); v.rs = 3'd4; v.rs_u = 1'b1; v.ex_r = 3'd4;
      step(v, E_ALL, F_NONE, 1'b0, 1'b0, 1'b0);

      // Branch squashes a RAW-hazarded instruction.
      v = idle(); v.rs = 3'd3; v.rs_u = 1'b1; v.ex_w = 1'b1; v.ex_r = 3'd3; v.br = 1'b1;
      step(v, E_ALL, F_BR, 1'b0, 1'b0, 1'b0);
      v = idle();
      step(v, E_ALL, F_NONE, 1'b0, 1'b0, 1'b0);

      // Four-cycle memory stall (branch ignored while frozen), then completion.
      v = idle(); v.req = 1'b1;
      step(v, E_MST, F_MST, 1'b0, 1'b0, 1'b0);
      v.br = 1'b1;
      step(v, E_MST, F_MST, 1'b0, 1'b0, 1'b0);
      v.br = 1'b0;
      step(v, E_MST, F_MST, 1'b0, 1'b0, 1'b0);
      step(v, E_MST, F_MST, 1'b0, 1'b0, 1'b0);
      v.done = 1'b1;
      step(v, E_ALL, F_NONE, 1'b0, 1'b0, 1'b0);
      v = idle();
      step(v, E_ALL, F_NONE, 1'b0, 1'b0, 1'b0);

      // Reset in MEM_WAIT, then halt_in beats a memory stall in RUN.
      v = idle(); v.req = 1'b1;
      step(v, E_MST, F_MST, 1'b0, 1'b0, 1'b0);
      step(v, E_MST, F_MST, 1'b0, 1'b0, 1'b0);
      v.rst = 1'b0;
      step(v, E_NONE, F_ALL, 1'b0, 1'b0, 1'b0);
      v = idle(); v.req = 1'b1; v.halt = 1'b1;
      step(v, E_NONE, F_NONE, 1'b0, 1'b0, 1'b0);
      v = idle();
      step(v, E_NONE, F_NONE, 1'b1, 1'b0, 1'b0);
      v = idle(); v.req = 1'b1; v.br = 1'b1;
      step(v, E_NONE, F_NONE, 1'b1, 1'b0, 1'b0);
      v = idle(); v.rst = 1'b0;
      step(v, E_NONE, F_ALL, 1'b0, 1'b0, 1'b0);
      v = idle();
      step(v, E_ALL, F_NONE, 1'b0, 1'b0, 1'b0);

      // Timeout: one RUN stall cycle, eight MEM_WAIT cycles, then sticky HALT.
      v = idle(); v.req = 1'b1;
      step(v, E_MST, F_MST, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(v, E_MST, F_MST, 1'b0, 1'b0, 1'b0);
      step(v, E_NONE, F_NONE, 1'b1, 1'b1, 1'b0);
      v = idle();
      step(v, E_NONE, F_NONE, 1'b1, 1'b1, 1'b0);
      v = idle(); v.rst = 1'b0;
      step(v, E_NONE, F_ALL, 1'b0, 1'b0, 1'b0);

      // mem_done in the timeout cycle wins: back to RUN, no error.
      v = idle(); v.req = 1'b1;
      step(v, E_MST, F_MST, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) step(v, E_MST, F_MST, 1'b0, 1'b0, 1'b0);
      v.done = 1'b1;
      step(v, E_ALL, F_NONE, 1'b0, 1'b0, 1'b0);
      v = idle(); v.halt = 1'b1;
      step(v, E_NONE, F_NONE, 1'b0, 1'b0, 1'b0);
      v = idle();
      step(v, E_NONE, F_NONE, 1'b1, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
